// File: rtl/tank_game_pkg.sv
// Shared tank-game types and screen geometry.
// Used by the turn controller, the bullet datapath and the tank modules.
package tank_game_pkg;

  typedef enum logic [2:0] {
    AIM       = 3'd0,
    LAUNCH    = 3'd1,
    FLIGHT    = 3'd2,
    RESOLVE   = 3'd3,
    COOLDOWN  = 3'd4,
    GAME_OVER = 3'd5
  } turn_state_t;

  localparam logic [9:0] X_MAX       = 10'd639;
  localparam logic [9:0] Y_MAX       = 10'd479;
  localparam logic [9:0] BULLET_SIZE = 10'd3;
  localparam logic [9:0] TANK_W      = 10'd40;
  localparam logic [9:0] TANK_H      = 10'd30;

endpackage

// File: rtl/bullet_hit_check.sv
// Combinational bullet tests: opponent hitbox overlap and screen-edge contact.
// All sums are 11 bits wide so a corner near the screen edge cannot wrap.
module bullet_hit_check
  import tank_game_pkg::*;
(
  input  logic [9:0] i_bullet_x,
  input  logic [9:0] i_bullet_y,
  input  logic [9:0] i_opp_x,
  input  logic [9:0] i_opp_y,
  output logic       o_hit,
  output logic       o_oob
);

  logic [10:0] w_bx;
  logic [10:0] w_by;
  logic [10:0] w_ox;
  logic [10:0] w_oy;
  logic [10:0] w_size;

  assign w_bx   = {1'b0, i_bullet_x};
  assign w_by   = {1'b0, i_bullet_y};
  assign w_ox   = {1'b0, i_opp_x};
  assign w_oy   = {1'b0, i_opp_y};
  assign w_size = {1'b0, BULLET_SIZE};

  assign o_hit = (w_bx >= w_ox) && (w_bx < w_ox + {1'b0, TANK_W}) &&
                 (w_by >= w_oy) && (w_by < w_oy + {1'b0, TANK_H});

  assign o_oob = (w_by + w_size >= {1'b0, Y_MAX}) || (w_by <= w_size) ||
                 (w_bx + w_size >= {1'b0, X_MAX}) || (w_bx <= w_size);

endmodule

// File: rtl/shot_turn_controller.sv
// Turn sequencer for the shared bullet: launch on the active tank's fire edge,
// track flight, resolve hit/miss/timeout, update hit points and pass the turn.
module shot_turn_controller
  import tank_game_pkg::*;
#(
  parameter int HP_INIT         = 5,
  parameter int ARM_FRAMES      = 2,
  parameter int FLIGHT_TIMEOUT  = 255,
  parameter int COOLDOWN_FRAMES = 30
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [1:0] fire_key,
  input  logic [9:0] BulletX,
  input  logic [9:0] BulletY,
  input  logic [9:0] Tank0X,
  input  logic [9:0] Tank0Y,
  input  logic [9:0] Tank1X,
  input  logic [9:0] Tank1Y,
  output logic       shoot,
  output logic [1:0] currentTank,
  output logic       hit_pulse,
  output logic [2:0] hp0,
  output logic [2:0] hp1,
  output logic [1:0] winner,
  output logic [2:0] state_dbg
);

  localparam logic [7:0] ARM_LAST = 8'(ARM_FRAMES - 1);
  localparam logic [7:0] FLT_LAST = 8'(FLIGHT_TIMEOUT);
  localparam logic [7:0] CD_LAST  = 8'(COOLDOWN_FRAMES - 1);
  localparam logic [2:0] HP_RST   = 3'(HP_INIT);

  turn_state_t r_state;
  logic [7:0]  r_cnt;
  logic [1:0]  r_fire_prev;
  logic        r_cur;
  logic        r_shoot;
  logic        r_hit_flag;
  logic        r_hit_pulse;
  logic [2:0]  r_hp0;
  logic [2:0]  r_hp1;
  logic [1:0]  r_winner;

  logic [9:0]  w_opp_x;
  logic [9:0]  w_opp_y;
  logic        w_hit;
  logic        w_oob;
  logic        w_fire_rise;

  assign w_opp_x     = r_cur ? Tank0X : Tank1X;
  assign w_opp_y     = r_cur ? Tank0Y : Tank1Y;
  assign w_fire_rise = fire_key[r_cur] & ~r_fire_prev[r_cur];

  bullet_hit_check u_hit_check (
    .i_bullet_x (BulletX),
    .i_bullet_y (BulletY),
    .i_opp_x    (w_opp_x),
    .i_opp_y    (w_opp_y),
    .o_hit      (w_hit),
    .o_oob      (w_oob)
  );

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_state     <= AIM;
      r_cnt       <= 8'd0;
      r_fire_prev <= 2'b11;
      r_cur       <= 1'b0;
      r_shoot     <= 1'b0;
      r_hit_flag  <= 1'b0;
      r_hit_pulse <= 1'b0;
      r_hp0       <= HP_RST;
      r_hp1       <= HP_RST;
      r_winner    <= 2'd0;
    end else begin
      r_fire_prev <= fire_key;
      r_hit_pulse <= 1'b0;
      case (r_state)
        AIM: begin
          if (w_fire_rise) begin
            r_state <= LAUNCH;
            r_cnt   <= 8'd0;
            r_shoot <= 1'b1;
          end
        end
        // Bullet is still at the muzzle here, so hit/oob are not consulted.
        LAUNCH: begin
          if (r_cnt == ARM_LAST) begin
            r_state <= FLIGHT;
            r_cnt   <= 8'd0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        // shoot drops on the landing edge so the datapath cannot relaunch.
        FLIGHT: begin
          if (w_hit) begin
            r_state     <= RESOLVE;
            r_hit_flag  <= 1'b1;
            r_hit_pulse <= 1'b1;
            r_shoot     <= 1'b0;
          end else if (w_oob || r_cnt == FLT_LAST) begin
            r_state    <= RESOLVE;
            r_hit_flag <= 1'b0;
            r_shoot    <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        RESOLVE: begin
          if (r_hit_flag) begin
            if (r_cur) r_hp0 <= (r_hp0 != 3'd0) ? r_hp0 - 3'd1 : 3'd0;
            else       r_hp1 <= (r_hp1 != 3'd0) ? r_hp1 - 3'd1 : 3'd0;
          end
          r_state <= COOLDOWN;
          r_cnt   <= 8'd0;
        end
        COOLDOWN: begin
          if (r_cnt == CD_LAST) begin
            if (r_hp0 == 3'd0 || r_hp1 == 3'd0) begin
              r_state  <= GAME_OVER;
              r_winner <= (r_hp0 != 3'd0) ? 2'd1 : 2'd2;
            end else begin
              r_state <= AIM;
              r_cur   <= ~r_cur;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        GAME_OVER: r_state <= GAME_OVER;
        default:   r_state <= AIM;
      endcase
    end
  end

  assign shoot       = r_shoot;
  assign currentTank = {1'b0, r_cur};
  assign hit_pulse   = r_hit_pulse;
  assign hp0         = r_hp0;
  assign hp1         = r_hp1;
  assign winner      = r_winner;
  assign state_dbg   = r_state;

endmodule

// File: tb/tb_shot_turn_controller.sv
// Bench for shot_turn_controller: table of complete turns scored through a queue,
// plus hand-written reset, held-key, game-over and mid-flight reset sequences.
module tb_shot_turn_controller;
  import tank_game_pkg::*;

  logic       frame_clk = 1'b0;
  logic       Reset;
  logic [1:0] fire_key;
  logic [9:0] BulletX, BulletY, Tank0X, Tank0Y, Tank1X, Tank1Y;
  logic       shoot;
  logic [1:0] currentTank;
  logic       hit_pulse;
  logic [2:0] hp0, hp1;
  logic [1:0] winner;
  logic [2:0] state_dbg;

  int checks = 0;
  int errors = 0;

  always #5 frame_clk = ~frame_clk;

  shot_turn_controller dut (
    .frame_clk   (frame_clk),
    .Reset       (Reset),
    .fire_key    (fire_key),
    .BulletX     (BulletX),
    .BulletY     (BulletY),
    .Tank0X      (Tank0X),
    .Tank0Y      (Tank0Y),
    .Tank1X      (Tank1X),
    .Tank1Y      (Tank1Y),
    .shoot       (shoot),
    .currentTank (currentTank),
    .hit_pulse   (hit_pulse),
    .hp0         (hp0),
    .hp1         (hp1),
    .winner      (winner),
    .state_dbg   (state_dbg)
  );

  typedef struct {
    logic [1:0] cur;
    logic [9:0] bx, by, t1x, t1y;
    logic       hold;
    logic       exp_hit;
    logic [2:0] exp_hp0, exp_hp1;
    int         exp_flight;
    logic [2:0] exp_after;
    logic [1:0] exp_winner;
  } row_t;

  typedef struct {
    logic       hit;
    logic [2:0] hp0, hp1;
    int         flight;
  } exp_t;

  row_t rows[11];
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    row_t r;
    exp_t e;
    int   n;
    logic held0;

    // cur, bx, by, t1x, t1y, hold, hit, hp0, hp1, flight, after, winner
    rows[0]  = '{2'd0, 10'd410, 10'd310, 10'd400, 10'd300, 1'b1, 1'b1, 3'd5, 3'd4, 1,   AIM,       2'd0};
    rows[1]  = '{2'd1, 10'd320, 10'd477, 10'd400, 10'd300, 1'b0, 1'b0, 3'd5, 3'd4, 1,   AIM,       2'd0};
    rows[2]  = '{2'd0, 10'd410, 10'd477, 10'd400, 10'd460, 1'b0, 1'b1, 3'd5, 3'd3, 1,   AIM,       2'd0};
    rows[3]  = '{2'd1, 10'd105, 10'd305, 10'd400, 10'd300, 1'b0, 1'b1, 3'd4, 3'd3, 1,   AIM,       2'd0};
    rows[4]  = '{2'd0, 10'd320, 10'd100, 10'd400, 10'd300, 1'b0, 1'b0, 3'd4, 3'd3, 256, AIM,       2'd0};
    rows[5]  = '{2'd1, 10'd2,   10'd100, 10'd400, 10'd300, 1'b0, 1'b0, 3'd4, 3'd3, 1,   AIM,       2'd0};
    rows[6]  = '{2'd0, 10'd410, 10'd310, 10'd400, 10'd300, 1'b0, 1'b1, 3'd4, 3'd2, 1,   AIM,       2'd0};
    rows[7]  = '{2'd1, 10'd320, 10'd3,   10'd400, 10'd300, 1'b0, 1'b0, 3'd4, 3'd2, 1,   AIM,       2'd0};
    rows[8]  = '{2'd0, 10'd439, 10'd329, 10'd400, 10'd300, 1'b0, 1'b1, 3'd4, 3'd1, 1,   AIM,       2'd0};
    rows[9]  = '{2'd1, 10'd140, 10'd310, 10'd400, 10'd300, 1'b0, 1'b0, 3'd4, 3'd1, 256, AIM,       2'd0};
    rows[10] = '{2'd0, 10'd400, 10'd300, 10'd400, 10'd300, 1'b0, 1'b1, 3'd4, 3'd0, 1,   GAME_OVER, 2'd1};

    Reset = 1'b1; fire_key = 2'b01;
    BulletX = 10'd320; BulletY = 10'd100;
    Tank0X = 10'd100; Tank0Y = 10'd300; Tank1X = 10'd400; Tank1Y = 10'd300;
    tick(); tick();
    chk("rst_state", 32'(state_dbg), 32'(AIM));
    chk("rst_shoot", 32'(shoot), 0);
    chk("rst_cur", 32'(currentTank), 0);
    chk("rst_pulse", 32'(hit_pulse), 0);
    chk("rst_hp0", 32'(hp0), 5);
    chk("rst_hp1", 32'(hp1), 5);
    chk("rst_winner", 32'(winner), 0);

    // Key held through reset release must not fire.
    Reset = 1'b0;
    repeat (3) tick();
    chk("held_through_reset", 32'(state_dbg), 32'(AIM));
    fire_key = 2'b00; tick();
    fire_key = 2'b10;
    repeat (3) tick();
    chk("inactive_key", 32'(state_dbg), 32'(AIM));
    fire_key = 2'b00; tick();

    held0 = 1'b0;
    for (int i = 0; i < 11; i++) begin
      r = rows[i];
      Tank1X = r.t1x; Tank1Y = r.t1y;
      BulletX = 10'd320; BulletY = 10'd100;
      chk("aim_state", 32'(state_dbg), 32'(AIM));
      chk("aim_cur", 32'(currentTank), 32'(r.cur));
      if (held0 && r.cur == 2'd0) begin
        repeat (3) tick();
        chk("held_across_turn", 32'(state_dbg), 32'(AIM));
        fire_key[0] = 1'b0;
        tick();
        held0 = 1'b0;
      end
      fire_key[r.cur[0]] = 1'b1;
      BulletX = r.bx; BulletY = r.by;
      e.hit = r.exp_hit; e.hp0 = r.exp_hp0; e.hp1 = r.exp_hp1; e.flight = r.exp_flight;
      sb.push_back(e);
      tick();
      if (!r.hold) fire_key[r.cur[0]] = 1'b0;
      chk("launch_shoot", 32'(shoot), 1);
      n = 0;
      while (state_dbg == LAUNCH && n < 10) begin n++; tick(); end
      chk("launch_frames", 32'(n), 2);
      n = 0;
      while (state_dbg == FLIGHT && n < 400) begin n++; tick(); end
      chk("resolve_state", 32'(state_dbg), 32'(RESOLVE));
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: empty at resolve");
      end else begin
        e = sb.pop_front();
        chk("flight_frames", 32'(n), 32'(e.flight));
        chk("hit_pulse", 32'(hit_pulse), 32'(e.hit));
        chk("resolve_shoot", 32'(shoot), 0);
        chk("flight_cur", 32'(currentTank), 32'(r.cur));
        tick();
        chk("pulse_one_frame", 32'(hit_pulse), 0);
        chk("hp0", 32'(hp0), 32'(e.hp0));
        chk("hp1", 32'(hp1), 32'(e.hp1));
      end
      n = 0;
      while (state_dbg == COOLDOWN && n < 100) begin
        n++;
        if (shoot !== 1'b0) begin errors++; $display("FAIL cooldown_shoot: got %0d expected 0", shoot); end
        tick();
      end
      checks++;
      chk("cooldown_frames", 32'(n), 30);
      chk("after_state", 32'(state_dbg), 32'(r.exp_after));
      chk("after_cur", 32'(currentTank),
          (r.exp_after == AIM) ? 32'(r.cur ^ 2'd1) : 32'(r.cur));
      chk("winner", 32'(winner), 32'(r.exp_winner));
      if (r.hold) held0 = 1'b1;
    end

    // Game over holds; fire is ignored.
    fire_key = 2'b00; tick();
    fire_key = 2'b01;
    repeat (4) tick();
    chk("go_state", 32'(state_dbg), 32'(GAME_OVER));
    chk("go_shoot", 32'(shoot), 0);
    chk("go_winner", 32'(winner), 1);
    chk("go_hp1", 32'(hp1), 0);
    fire_key = 2'b00;

    // Reset out of game over restores hit points.
    #3 Reset = 1'b1;
    #1;
    chk("rst_go_hp1", 32'(hp1), 5);
    chk("rst_go_winner", 32'(winner), 0);
    chk("rst_go_state", 32'(state_dbg), 32'(AIM));
    tick();
    Reset = 1'b0;
    Tank1X = 10'd400; Tank1Y = 10'd300;
    BulletX = 10'd320; BulletY = 10'd100;
    tick();
    fire_key = 2'b01; tick();
    chk("relaunch_state", 32'(state_dbg), 32'(LAUNCH));
    fire_key = 2'b00;
    tick(); tick();
    chk("reflight_state", 32'(state_dbg), 32'(FLIGHT));
    chk("reflight_shoot", 32'(shoot), 1);

    // Reset mid-flight, between clock edges.
    #3 Reset = 1'b1;
    #1;
    chk("async_shoot", 32'(shoot), 0);
    chk("async_state", 32'(state_dbg), 32'(AIM));
    chk("async_hp0", 32'(hp0), 5);
    chk("async_hp1", 32'(hp1), 5);
    tick();
    Reset = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
